sparse_coo_scheduler: RTL and testbench

Sequencing controller for the sparse COO matrix-multiply datapath. It holds the A and B COO entry tables (FP8 E4M3 value, row, col, valid). On `start` it clears the accumulators, then walks every A entry against every B entry. For each index-matched pair it issues one multiply-accumulate request (`C[A_row][B_col] += A·B`) to the FP32 MAC/accumulator array over a valid/ready handshake. It replaces hierarchical pokes into the matmul's tables with a proper load port and a deterministic issue order.

---
 rtl/sparse_coo_scheduler_if.sv | 36 +++
 rtl/sparse_coo_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sparse_coo_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_coo_scheduler_if.sv
// Load port and MAC request channel of the sparse COO scheduler.
// master = scheduler side (accepts table writes, issues MAC requests); slave = environment side.
interface sparse_coo_scheduler_if #(
   parameter int unsigned NNZ    = 32,
   parameter int unsigned DIM    = 8,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned IW = $clog2(NNZ);
   localparam int unsigned RW = $clog2(DIM);

   logic              ld_valid;
   logic              ld_ready;
   logic              ld_sel;
   logic [IW-1:0]     ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [RW-1:0]     ld_row;
   logic [RW-1:0]     ld_col;
   logic              ld_en;

   logic              mac_valid;
   logic              mac_ready;
   logic [RW-1:0]     mac_row;
   logic [RW-1:0]     mac_col;
   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;

   modport master (
      input  ld_valid, ld_sel, ld_addr, ld_data, ld_row, ld_col, ld_en, mac_ready,
      output ld_ready, mac_valid, mac_row, mac_col, mac_a, mac_b
   );

   modport slave (
      output ld_valid, ld_sel, ld_addr, ld_data, ld_row, ld_col, ld_en, mac_ready,
      input  ld_ready, mac_valid, mac_row, mac_col, mac_a, mac_b
   );
endinterface

// File: rtl/sparse_coo_scheduler.sv
// Walks the A x B COO tables and issues one MAC request per index-matched pair.
// Optional SPARSE_SCHED_ROW_SKIP_EN: skip the inner loop for an invalid A entry in one cycle.
module sparse_coo_scheduler #(
   parameter int unsigned NNZ    = 32,
   parameter int unsigned DIM    = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         acc_clr,
   output logic [$clog2(NNZ*NNZ+1)-1:0] pair_count,
   sparse_coo_scheduler_if.master       bus
);
   localparam int unsigned IW = $clog2(NNZ);
   localparam int unsigned RW = $clog2(DIM);
   localparam int unsigned CW = $clog2(NNZ*NNZ+1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NNZ-1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SCAN  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [IW-1:0]     ia_q, ia_d, ib_q, ib_d;
   logic [CW-1:0]     pair_count_q, pair_count_d;
   logic [RW-1:0]     mac_row_q, mac_row_d, mac_col_q, mac_col_d;
   logic [DATA_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
   logic              busy_q, busy_d, done_q, done_d, acc_clr_q, acc_clr_d;
   logic              mac_valid_q, mac_valid_d, ld_ready_q, ld_ready_d;
   logic [NNZ-1:0]    a_vld_q, a_vld_d, b_vld_q, b_vld_d;

   logic [DATA_W-1:0] a_val_q [NNZ];
   logic [RW-1:0]     a_row_q [NNZ];
   logic [RW-1:0]     a_col_q [NNZ];
   logic [DATA_W-1:0] b_val_q [NNZ];
   logic [RW-1:0]     b_row_q [NNZ];
   logic [RW-1:0]     b_col_q [NNZ];

   logic              ld_we_c, match_c, skip_row_c, ib_wrap_c, last_pair_c;
   logic [IW-1:0]     adv_ia_c, adv_ib_c;

   assign ld_we_c     = bus.ld_valid && ld_ready_q;
   assign match_c     = a_vld_q[ia_q] && b_vld_q[ib_q] && (b_row_q[ib_q] == a_col_q[ia_q]);
   assign ib_wrap_c   = (ib_q == LAST_IDX);
   assign last_pair_c = ib_wrap_c && (ia_q == LAST_IDX);
   assign adv_ib_c    = ib_q + IW'(1);
   assign adv_ia_c    = ib_wrap_c ? ia_q + IW'(1) : ia_q;

`ifdef SPARSE_SCHED_ROW_SKIP_EN
   assign skip_row_c  = !a_vld_q[ia_q];
`else
   assign skip_row_c  = 1'b0;
`endif

   // Table storage: payload fields are not reset, only the valid bits are
   always_ff @(posedge clk) begin
      if (ld_we_c) begin
         if (bus.ld_sel) begin
            b_val_q[bus.ld_addr] <= bus.ld_data;
            b_row_q[bus.ld_addr] <= bus.ld_row;
            b_col_q[bus.ld_addr] <= bus.ld_col;
         end else begin
            a_val_q[bus.ld_addr] <= bus.ld_data;
            a_row_q[bus.ld_addr] <= bus.ld_row;
            a_col_q[bus.ld_addr] <= bus.ld_col;
         end
      end
   end

   // Next-state, counters, payload capture and registered output decode
   always_comb begin
      state_d      = state_q;
      ia_d         = ia_q;
      ib_d         = ib_q;
      pair_count_d = pair_count_q;
      mac_row_d    = mac_row_q;
      mac_col_d    = mac_col_q;
      mac_a_d      = mac_a_q;
      mac_b_d      = mac_b_q;
      a_vld_d      = a_vld_q;
      b_vld_d      = b_vld_q;

      if (ld_we_c) begin
         if (bus.ld_sel) b_vld_d[bus.ld_addr] = bus.ld_en;
         else            a_vld_d[bus.ld_addr] = bus.ld_en;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_CLEAR;
               pair_count_d = '0;
               ia_d         = '0;
               ib_d         = '0;
            end
         end
         S_CLEAR: state_d = S_SCAN;
         S_SCAN: begin
            if (match_c) begin
               mac_row_d = a_row_q[ia_q];
               mac_col_d = b_col_q[ib_q];
               mac_a_d   = a_val_q[ia_q];
               mac_b_d   = b_val_q[ib_q];
               state_d   = S_ISSUE;
            end else if (skip_row_c) begin
               ib_d    = '0;
               ia_d    = ia_q + IW'(1);
               state_d = (ia_q == LAST_IDX) ? S_DONE : S_SCAN;
            end else begin
               ib_d    = adv_ib_c;
               ia_d    = adv_ia_c;
               state_d = last_pair_c ? S_DONE : S_SCAN;
            end
         end
         S_ISSUE: begin
            if (bus.mac_ready) begin
               pair_count_d = pair_count_q + CW'(1);
               ib_d         = adv_ib_c;
               ia_d         = adv_ia_c;
               state_d      = last_pair_c ? S_DONE : S_SCAN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d == S_CLEAR) || (state_d == S_SCAN) || (state_d == S_ISSUE);
      done_d      = (state_d == S_DONE);
      acc_clr_d   = (state_d == S_CLEAR);
      mac_valid_d = (state_d == S_ISSUE);
      ld_ready_d  = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ia_q         <= '0;
         ib_q         <= '0;
         pair_count_q <= '0;
         mac_row_q    <= '0;
         mac_col_q    <= '0;
         mac_a_q      <= '0;
         mac_b_q      <= '0;
         a_vld_q      <= '0;
         b_vld_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         acc_clr_q    <= 1'b0;
         mac_valid_q  <= 1'b0;
         ld_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         ia_q         <= ia_d;
         ib_q         <= ib_d;
         pair_count_q <= pair_count_d;
         mac_row_q    <= mac_row_d;
         mac_col_q    <= mac_col_d;
         mac_a_q      <= mac_a_d;
         mac_b_q      <= mac_b_d;
         a_vld_q      <= a_vld_d;
         b_vld_q      <= b_vld_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         acc_clr_q    <= acc_clr_d;
         mac_valid_q  <= mac_valid_d;
         ld_ready_q   <= ld_ready_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign acc_clr       = acc_clr_q;
   assign pair_count    = pair_count_q;
   assign bus.ld_ready  = ld_ready_q;
   assign bus.mac_valid = mac_valid_q;
   assign bus.mac_row   = mac_row_q;
   assign bus.mac_col   = mac_col_q;
   assign bus.mac_a     = mac_a_q;
   assign bus.mac_b     = mac_b_q;
endmodule

// File: tb/tb_sparse_coo_scheduler.sv
// Directed bench for sparse_coo_scheduler: 8-entry load, backpressure, blocked load, reset abort.
// Honours SPARSE_SCHED_ROW_SKIP_EN for the expected busy-cycle counts.
module tb_sparse_coo_scheduler;
   localparam int unsigned NNZ    = 32;
   localparam int unsigned DIM    = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CW     = $clog2(NNZ*NNZ+1);
`ifdef SPARSE_SCHED_ROW_SKIP_EN
   localparam int EXP_BUSY_8 = 1 + 298;
   localparam int EXP_BUSY_0 = 1 + 32;
`else
   localparam int EXP_BUSY_8 = 1 + 1042;
   localparam int EXP_BUSY_0 = 1 + 1024;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, acc_clr;
   logic [CW-1:0] pair_count;

   sparse_coo_scheduler_if #(.NNZ(NNZ), .DIM(DIM), .DATA_W(DATA_W)) bus ();

   sparse_coo_scheduler #(.NNZ(NNZ), .DIM(DIM), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .acc_clr    (acc_clr),
      .pair_count (pair_count),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Observation counters, sampled on the falling edge
   int          cyc = 0;
   int          busy_cnt = 0, done_cnt = 0, acc_cnt = 0, valid_cnt = 0, hs_cnt = 0;
   int          last_busy_cyc = 0, done_cyc = 0, acc_cyc = 0, done_pc = 0;
   logic [21:0] hs_pay [128];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy) begin busy_cnt++; last_busy_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; done_pc = int'(pair_count); end
      if (acc_clr) begin acc_cnt++; acc_cyc = cyc; end
      if (bus.mac_valid) valid_cnt++;
      if (bus.mac_valid && bus.mac_ready) begin
         if (hs_cnt < 128) hs_pay[hs_cnt] = {bus.mac_row, bus.mac_col, bus.mac_a, bus.mac_b};
         hs_cnt++;
      end
   end

   int b_busy, b_done, b_acc, b_valid, b_hs, start_cyc;

   task automatic snap();
      b_busy = busy_cnt; b_done = done_cnt; b_acc = acc_cnt; b_valid = valid_cnt; b_hs = hs_cnt;
   endtask

   task automatic load(input logic sel, input int addr, input logic [7:0] val,
                       input int row, input int col);
      bus.ld_valid = 1'b1;
      bus.ld_sel   = sel;
      bus.ld_addr  = 5'(addr);
      bus.ld_data  = val;
      bus.ld_row   = 3'(row);
      bus.ld_col   = 3'(col);
      bus.ld_en    = 1'b1;
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
   endtask

   task automatic load_all();
      logic [7:0] vals [8];
      int a_r [8], a_c [8], b_r [8], b_c [8];
      vals = '{8'h38, 8'h40, 8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70};
      a_r  = '{0, 0, 0, 1, 1, 1, 2, 2};
      a_c  = '{0, 1, 2, 0, 1, 2, 0, 1};
      b_r  = '{0, 1, 2, 3, 1, 1, 2, 2};
      b_c  = '{0, 1, 2, 3, 1, 2, 0, 1};
      for (int i = 0; i < 8; i++) load(1'b0, i, vals[i], a_r[i], a_c[i]);
      for (int i = 0; i < 8; i++) load(1'b1, i, vals[i], b_r[i], b_c[i]);
   endtask

   task automatic do_start();
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         if (done_cnt > b_done) break;
      end
      check_eq(tag, 32'(done_cnt > b_done), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.mac_valid) break;
      end
      check_eq(tag, 32'(bus.mac_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
      bus.ld_row = '0; bus.ld_col = '0; bus.ld_en = 1'b0; bus.mac_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check_eq("rst_busy",     32'(busy),          32'd0);
      check_eq("rst_done",     32'(done),          32'd0);
      check_eq("rst_acc_clr",  32'(acc_clr),       32'd0);
      check_eq("rst_mac_v",    32'(bus.mac_valid), 32'd0);
      check_eq("rst_payload",  32'({bus.mac_row, bus.mac_col, bus.mac_a, bus.mac_b}), 32'd0);
      check_eq("rst_pair_cnt", 32'(pair_count),    32'd0);
      check_eq("rst_ld_ready", 32'(bus.ld_ready),  32'd1);
      @(posedge clk); #1;
      load_all();

      // Basic run with mac_ready high: order, count, clear pulse, cycle budget
      snap();
      do_start();
      wait_done("t1_done_seen");
      check_eq("t1_hs_cnt",     32'(hs_cnt - b_hs),           32'd18);
      check_eq("t1_mac0",       32'(hs_pay[b_hs]),            32'({3'd0, 3'd0, 8'h38, 8'h38}));
      check_eq("t1_mac1",       32'(hs_pay[b_hs + 1]),        32'({3'd0, 3'd1, 8'h40, 8'h40}));
      check_eq("t1_done_pc",    32'(done_pc),                 32'd18);
      check_eq("t1_acc_pulses", 32'(acc_cnt - b_acc),         32'd1);
      check_eq("t1_acc_cyc",    32'(acc_cyc - start_cyc),     32'd1);
      check_eq("t2_busy_cyc",   32'(busy_cnt - b_busy),       32'(EXP_BUSY_8));
      check_eq("t2_done_after", 32'(done_cyc - last_busy_cyc), 32'd1);
      check_eq("t1_done_cnt",   32'(done_cnt - b_done),       32'd1);
      check_eq("t1_pc_hold",    32'(pair_count),              32'd18);
      check_eq("t1_ld_ready",   32'(bus.ld_ready),            32'd1);

      // Backpressure on the first request
      bus.mac_ready = 1'b0;
      snap();
      do_start();
      wait_valid("t3_valid_seen");
      for (int i = 0; i < 5; i++) begin
         check_eq("t3_hold_valid", 32'(bus.mac_valid), 32'd1);
         check_eq("t3_hold_pay",   32'({bus.mac_row, bus.mac_col, bus.mac_a, bus.mac_b}),
                  32'({3'd0, 3'd0, 8'h38, 8'h38}));
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      bus.mac_ready = 1'b1;
      wait_done("t3_done_seen");
      check_eq("t3_pair_cnt", 32'(pair_count),     32'd18);
      check_eq("t3_hs_cnt",   32'(hs_cnt - b_hs),  32'd18);

      // Load attempt while busy is dropped
      snap();
      do_start();
      repeat (3) begin @(posedge clk); #1; end
      bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 5'd9; bus.ld_data = 8'h11;
      bus.ld_row = 3'd3; bus.ld_col = 3'd0; bus.ld_en = 1'b1;
      @(negedge clk);
      check_eq("t4_ld_ready", 32'(bus.ld_ready), 32'd0);
      check_eq("t4_busy",     32'(busy),         32'd1);
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      wait_done("t4_done_seen");
      check_eq("t4_done_pc", 32'(done_pc), 32'd18);

      // start pulsed mid-scan is ignored
      snap();
      do_start();
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t6_done_seen");
      repeat (20) begin @(posedge clk); #1; end
      check_eq("t6_done_cnt", 32'(done_cnt - b_done), 32'd1);
      check_eq("t6_busy_cyc", 32'(busy_cnt - b_busy), 32'(EXP_BUSY_8));
      check_eq("t6_idle",     32'(busy),              32'd0);

      // Reset during ISSUE, then a run on empty tables
      bus.mac_ready = 1'b0;
      snap();
      do_start();
      wait_valid("t5_valid_seen");
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(negedge clk);
      check_eq("t5_rst_mac_v", 32'(bus.mac_valid),    32'd0);
      check_eq("t5_rst_pc",    32'(pair_count),       32'd0);
      check_eq("t5_no_done",   32'(done_cnt - b_done), 32'd0);
      check_eq("t5_rst_busy",  32'(busy),             32'd0);
      @(posedge clk); #1;
      bus.mac_ready = 1'b1;
      snap();
      do_start();
      wait_done("t5_done_seen");
      check_eq("t5_mac_valid", 32'(valid_cnt - b_valid), 32'd0);
      check_eq("t5_done_pc",   32'(done_pc),             32'd0);
      check_eq("t5_busy_cyc",  32'(busy_cnt - b_busy),   32'(EXP_BUSY_0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
